// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - two-group clock-gate enable controller with hold-off and gated-cycle counters
// Each group runs an identical channel; only FORCE_ON, CNT_CLR and RST are shared.

module clk_gate_chan #(
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             force_on,
    input  logic             cnt_clr,
    output logic             gclk_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] gated_cnt
);
    typedef enum logic [1:0] {
        GATED  = 2'b00,
        ACTIVE = 2'b01,
        HOLD   = 2'b10
    } chan_state_e;

    localparam logic [7:0] HOLD_LOAD = 8'(IDLE_CYCLES);

    logic [7:0]  hcnt;
    chan_state_e state_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= 8'd0;
        end else if (en) begin
            hcnt <= HOLD_LOAD;
        end else if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
        end
    end

    // Enable is combinational so a request opens the gate in the same cycle.
    assign gclk_en = en | (hcnt != 8'd0) | force_on;

    always_comb begin
        state_c = GATED;
        if (en) begin
            state_c = ACTIVE;
        end else if (hcnt != 8'd0) begin
            state_c = HOLD;
        end
    end

    assign state = state_c;

    // Clear beats increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            gated_cnt <= '0;
        end else if (!gclk_en && (gated_cnt != '1)) begin
            gated_cnt <= gated_cnt + CNT_W'(1);
        end
    end
endmodule

module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En1,
    input  logic             En2,
    input  logic             FORCE_ON,
    input  logic             CNT_CLR,
    output logic             GCLK_EN1,
    output logic             GCLK_EN2,
    output logic [1:0]       STATE1,
    output logic [1:0]       STATE2,
    output logic [CNT_W-1:0] GATED_CNT1,
    output logic [CNT_W-1:0] GATED_CNT2
);
    clk_gate_chan #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chan1 (
        .clk       (CLK),
        .rst       (RST),
        .en        (En1),
        .force_on  (FORCE_ON),
        .cnt_clr   (CNT_CLR),
        .gclk_en   (GCLK_EN1),
        .state     (STATE1),
        .gated_cnt (GATED_CNT1)
    );

    clk_gate_chan #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chan2 (
        .clk       (CLK),
        .rst       (RST),
        .en        (En2),
        .force_on  (FORCE_ON),
        .cnt_clr   (CNT_CLR),
        .gclk_en   (GCLK_EN2),
        .state     (STATE2),
        .gated_cnt (GATED_CNT2)
    );
endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 4, meaning the hold-off cycles after an enable drops before a group is gated; legal range 0..255.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each gated-cycle counter.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 En1  input  1  group-1 register-update request, from the upstream datapath.
REQ-006 En2  input  1  group-2 register-update request.
REQ-007 FORCE_ON  input  1  test/debug override that holds both gate enables high.
REQ-008 CNT_CLR  input  1  synchronous clear of both gated-cycle counters.
REQ-009 GCLK_EN1  output  1  enable to the group-1 integrated clock-gating cell.
REQ-010 GCLK_EN2  output  1  enable to the group-2 integrated clock-gating cell.
REQ-011 STATE1  output  2  group-1 state: 00 GATED, 01 ACTIVE, 10 HOLD.
REQ-012 STATE2  output  2  group-2 state, same encoding.
REQ-013 GATED_CNT1  output  CNT_W  count of cycles in which GCLK_EN1 was low.
REQ-014 GATED_CNT2  output  CNT_W  count of cycles in which GCLK_EN2 was low.

Function
REQ-015 Each group n SHALL be an independent, identical channel with an 8-bit hold counter hcnt_n.
REQ-016 On a posedge with En_n=1, hcnt_n SHALL load IDLE_CYCLES.
REQ-017 On a posedge with En_n=0 and hcnt_n>0, hcnt_n SHALL decrement by 1; it SHALL never wrap below 0.
REQ-018 GCLK_EN_n SHALL be combinational: En_n OR (hcnt_n!=0) OR FORCE_ON, with zero-cycle latency from En_n.
REQ-019 Equivalently, GCLK_EN_n SHALL be high in cycle t iff FORCE_ON is high, or En_n was high in at least one cycle of t-IDLE_CYCLES..t.
REQ-020 With IDLE_CYCLES=0, GCLK_EN_n SHALL equal En_n OR FORCE_ON.
REQ-021 STATE_n SHALL be combinational: ACTIVE if En_n=1; HOLD if En_n=0 and hcnt_n!=0; GATED otherwise.
REQ-022 FORCE_ON SHALL NOT affect STATE_n or hcnt_n, only GCLK_EN_n.
REQ-023 Each posedge on which GCLK_EN_n=0 SHALL increment GATED_CNT_n by 1.
REQ-024 GATED_CNT_n SHALL saturate at all-ones and SHALL NOT wrap.
REQ-025 When CNT_CLR=1, both counters SHALL load 0 on that edge; clear SHALL take priority over increment.
REQ-026 CNT_CLR SHALL NOT affect hcnt_n.
REQ-027 When En_n re-asserts during HOLD, hcnt_n SHALL reload to IDLE_CYCLES and GCLK_EN_n SHALL stay high with no low glitch cycle.
REQ-028 When En1 and En2 toggle simultaneously, the two channels SHALL respond independently, with no cross-coupling.

Reset
REQ-029 When RST=1 at a posedge, hcnt1, hcnt2, GATED_CNT1 and GATED_CNT2 SHALL become 0; RST SHALL take priority over every other input.
REQ-030 After reset, with En_n=0 and FORCE_ON=0, STATE_n SHALL be GATED and GCLK_EN_n SHALL be 0.
REQ-031 A reset asserted mid-HOLD SHALL gate that group on the next cycle, even though its hold-off had not expired.

Verification
REQ-032 Hold-off (IDLE_CYCLES=4): En1 high for cycle 0 only -> GCLK_EN1 high in cycles 0..4 and low from cycle 5; STATE1 sequence 01,10,10,10,10,00; GATED_CNT1 increments from the edge ending cycle 5.
REQ-033 Re-trigger: En1 pulses at cycles 0 and 3 -> GCLK_EN1 continuously high in cycles 0..7, low at cycle 8.
REQ-034 Independence: En1 held high and En2 held low for 20 cycles after reset -> GCLK_EN1=1 and GATED_CNT1=0 throughout; GATED_CNT2 reaches 20.
REQ-035 Override/clear: with FORCE_ON=1 for 10 cycles and both enables low, both GCLK_EN stay 1, STATE=00 and counters hold; then a CNT_CLR pulse -> both counters read 0 on the next cycle.
REQ-036 Saturation (CNT_W=4): group gated for 20 cycles -> GATED_CNT reads 15 and stays 15.
REQ-037 Reset mid-HOLD: En2 pulse at cycle 0, RST at cycle 2 -> GCLK_EN2=0 from cycle 3 and all counters read 0.
